// File: rtl/acc_tracer_pkg.sv
// acc_tracer_pkg: shared state type and record constants for the accumulator tracer
package acc_tracer_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam logic [1:0] TAG_DATA = 2'b01;
  localparam logic [7:0] MARKER_HALT = 8'hFF;
  localparam int FRAME_BITS = 10;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous fifo with pointers and an occupancy counter
module trace_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  assign wr = push & (~full | pop);
  assign rd = pop & ~empty;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wr ? wp + AW'(1) : wp;
      rp <= rd ? rp + AW'(1) : rp;
      count <= count + CW'(wr) - CW'(rd);
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end
endmodule

// File: rtl/acc_tracer.sv
// acc_tracer: records accumulator changes and halt markers, streams them out as 8N1 serial
module acc_tracer
  import acc_tracer_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int DEPTH = 8,
  parameter int BAUD_DIV = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            acc,
  input  logic                         halt,
  output logic                         tx,
  output logic                         busy,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam int DATA_BITS = FRAME_BITS - 2;
  logic [DATA_W-1:0] prev_acc;
  logic halt_q, pend;
  logic data_push, mark_push, push, pop, full, empty;
  logic [7:0] rec, head, shreg, shreg_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0] bit_cnt, bit_n;
  logic baud_end, tx_n;
  tx_state_t state, state_n;
  assign data_push = acc != prev_acc;
  assign mark_push = pend & ~data_push;
  assign push = data_push | mark_push;
  assign rec = data_push ? {TAG_DATA, 6'(acc)} : MARKER_HALT;
  assign busy = state != IDLE || count != '0;
  assign baud_end = baud == BW'(BAUD_DIV - 1);
  trace_fifo #(.W(8), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(rec),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bit_n = bit_cnt;
    pop = 1'b0;
    baud_n = (state == IDLE || baud_end) ? '0 : baud + BW'(1);
    case (state)
      IDLE: begin
        pop = ~empty;
        shreg_n = empty ? shreg : head;
        bit_n = '0;
        state_n = empty ? IDLE : START;
      end
      START: state_n = baud_end ? DATA : START;
      DATA: if (baud_end) begin
        shreg_n = shreg >> 1;
        bit_n = bit_cnt + 3'd1;
        state_n = bit_cnt == 3'(DATA_BITS - 1) ? STOP : DATA;
      end
      STOP: state_n = baud_end ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      baud <= '0;
      bit_cnt <= '0;
      tx <= 1'b1;
      prev_acc <= '0;
      halt_q <= 1'b0;
      pend <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      baud <= baud_n;
      bit_cnt <= bit_n;
      tx <= tx_n;
      prev_acc <= acc;
      halt_q <= halt;
      pend <= (pend & ~mark_push) | (halt & ~halt_q);
      overflow <= overflow | (push & full & ~pop);
    end
  end
endmodule
